i2s_tx_serializer: RTL and testbench
====================================

# i2s_tx_serializer

Stereo I2S transmitter that converts parallel left/right PCM samples into a Philips-format serial stream (bit clock, word select, data) for the external amplifier. It sits directly downstream of the S/PDIF decoder's sample output inside the top-level core and drives the dedicated I2S output pins. It has a one-frame holding buffer with a valid/ready handshake and underrun detection.

## Interface
Parameters:
- DATA_W, 24, sample width in bits (1..SLOT_W)
- SLOT_W, 32, bit-clock periods per channel slot
- BCK_DIV, 4, clk cycles per bit-clock period (even, >= 2)

Ports:
- clk  in  1  system clock; all logic on rising edge
- resetb  in  1  asynchronous active-low reset
- ena  in  1  block enable; low forces the reset state synchronously
- sample_l  in  DATA_W  left sample, two's complement
- sample_r  in  DATA_W  right sample, two's complement
- sample_valid  in  1  sample_l/sample_r valid
- sample_ready  out  1  holding buffer empty; transfer when valid && ready
- i2s_bck  out  1  bit clock
- i2s_ws  out  1  word select (0 = left, 1 = right)
- i2s_d0  out  1  serial data, MSB first
- underrun  out  1  one-cycle pulse: frame started with empty buffer
- underrun_cnt  out  8  saturating underrun counter

## Operation
- Clock and reset: one clock domain. resetb is asynchronous and active-low. ena=0 acts as a synchronous reset to the same state.
- Reset state:
  - All outputs 0 except sample_ready=1.
  - div_cnt=0, bit_cnt=0, holding buffer empty, frame register zero.
- Divider:
  - div_cnt counts 0..BCK_DIV-1 and wraps.
  - i2s_bck = 0 while div_cnt < BCK_DIV/2, else 1 (registered).
  - A "fall event" is the wrap of div_cnt to 0.
- Bit counter:
  - bit_cnt has range 0..2*SLOT_W-1 and advances on each fall event, wrapping to 0.
  - The wrap to 0 is the "frame boundary".
- Word select:
  - i2s_ws = 1 when bit_cnt is in [SLOT_W-1, 2*SLOT_W-2], else 0.
  - This makes WS lead each channel's MSB by one bck period.
- Data:
  - For bit_cnt = k < SLOT_W, i2s_d0 = left bit (DATA_W-1-k) for k < DATA_W, else 0.
  - For k >= SLOT_W, the right channel follows the same rule with k-SLOT_W.
- Holding buffer:
  - One stereo entry. sample_ready = buffer empty (registered).
  - A handshake writes the buffer and sets it full.
- Frame load: at each frame boundary, the frame register loads from the buffer.
  - Buffer full: load its contents and empty the buffer.
  - Buffer empty: load zeros, pulse underrun for one clk, and increment underrun_cnt (saturates at 255).
- Exception: the first frame boundary after reset or ena rising is a load but never flags underrun.
- Simultaneous handshake and frame load with the buffer empty:
  - The frame loads zeros and flags underrun.
  - The incoming sample goes into the buffer and plays in the following frame.
- Buffer full at a frame load: sample_ready is 0 that cycle, so no simultaneous write can occur. sample_ready returns to 1 in the next cycle.
- Reset or ena low mid-frame: the stream aborts immediately and outputs go to the reset state. A buffered sample is discarded. underrun_cnt clears only on resetb, not on ena.

## Timing
- Period lengths:
  - bck period = BCK_DIV clk.
  - frame = 2*SLOT_W*BCK_DIV clk (default 256).
- i2s_ws and i2s_d0 change only on the same clk edge where i2s_bck falls. The receiver samples on the bck rise, which comes BCK_DIV/2 clk later.
- The first fall event after reset occurs BCK_DIV clk after resetb deasserts. bit_cnt then becomes 1, so the first full frame boundary occurs after 2*SLOT_W fall events.
- Latency: a sample accepted while the buffer is empty appears at the next frame boundary. Its left MSB is on i2s_d0 in the same cycle the boundary fall occurs.
- Frame register loads and the underrun pulse coincide with the boundary fall edge.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- Default parameters, a single handshake of L=0x800001, R=0x7FFFFE before the first boundary:
  - Next frame: ws=0 slot shifts 1,0…0,1 then 8 zeros.
  - ws=1 slot shifts 0,1…1,0 then 8 zeros.
  - ws rises at bit_cnt 31 and falls at 63.
- Continuous valid with a new sample each frame (8 frames): every sample is played exactly once in order. underrun stays 0 and sample_ready pulses low/high once per frame.
- No samples after the first frame: zeros are shifted out, underrun pulses once per boundary, and underrun_cnt reaches 255 and holds after 300 frames.
- Valid asserted in the exact cycle of a boundary with the buffer empty: that frame is zeros with underrun=1, and the sample plays in the next frame.
- Valid held high while the buffer is full for 100 clk: only one transfer occurs, and the earlier buffered sample is not overwritten.
- Reset mid-frame (bit_cnt=40):
  - Outputs go to 0 and sample_ready to 1 immediately (asynchronously).
  - underrun_cnt clears.
  - After release, bck restarts with period 4 clk and ws low.

Source files
------------

// File: rtl/i2s_tx_serializer_if.sv
// Sample handshake bundle between the upstream PCM source and the I2S serializer.
interface i2s_tx_serializer_if #(
    parameter int DATA_W = 24
);
    logic [DATA_W-1:0] sample_l;
    logic [DATA_W-1:0] sample_r;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output sample_l,
        output sample_r,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_l,
        input  sample_r,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/i2s_tx_serializer.sv
// Philips-format stereo I2S transmitter with a one-frame holding buffer,
// valid/ready sample intake and underrun detection.
module i2s_tx_serializer #(
    parameter int DATA_W  = 24,
    parameter int SLOT_W  = 32,
    parameter int BCK_DIV = 4
) (
    input  logic               clk,
    input  logic               resetb,
    input  logic               ena,
    i2s_tx_serializer_if.slave smp,
    output logic               i2s_bck,
    output logic               i2s_ws,
    output logic               i2s_d0,
    output logic               underrun,
    output logic [7:0]         underrun_cnt
);
    localparam int DIV_W = (BCK_DIV > 2) ? $clog2(BCK_DIV) : 1;
    localparam int BIT_W = $clog2(2 * SLOT_W);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
    localparam logic [BIT_W-1:0] WS_LO    = BIT_W'(SLOT_W - 1);
    localparam logic [BIT_W-1:0] WS_HI    = BIT_W'(2 * SLOT_W - 2);
    localparam logic [BIT_W-1:0] SLOT     = BIT_W'(SLOT_W);
    localparam logic [BIT_W-1:0] DW       = BIT_W'(DATA_W);

    // PRIME covers the span up to the first frame boundary after reset/enable,
    // which loads the buffer but never reports an underrun.
    typedef enum logic {
        ST_PRIME,
        ST_RUN
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              flag_underrun;

    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_next;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BIT_W-1:0]  bit_next;
    logic              fall;
    logic              boundary;
    logic              take;

    logic              hold_empty;
    logic [DATA_W-1:0] hold_l;
    logic [DATA_W-1:0] hold_r;
    logic [DATA_W-1:0] frame_l;
    logic [DATA_W-1:0] frame_r;
    logic [DATA_W-1:0] frame_l_next;
    logic [DATA_W-1:0] frame_r_next;

    logic [BIT_W-1:0]  pos;
    logic [DATA_W-1:0] word;
    logic              ws_next;
    logic              d0_next;

    assign smp.sample_ready = hold_empty;

    // Frame-state register: returns to PRIME on reset or while disabled.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state <= ST_PRIME;
        end else if (!ena) begin
            state <= ST_PRIME;
        end else begin
            state <= state_next;
        end
    end

    // Frame-state transitions and underrun decision at each frame boundary.
    always_comb begin
        state_next    = state;
        flag_underrun = 1'b0;
        case (state)
            ST_PRIME: begin
                if (boundary) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (boundary && hold_empty) begin
                    flag_underrun = 1'b1;
                end
            end
            default: state_next = ST_PRIME;
        endcase
    end

    // Divider, bit counter, frame reload and next serial bit, all evaluated
    // against post-edge values so ws/d0 land on the same edge bck falls.
    always_comb begin
        fall     = (div_cnt == DIV_LAST);
        div_next = fall ? '0 : div_cnt + DIV_W'(1);
        boundary = fall && (bit_cnt == BIT_LAST);
        bit_next = bit_cnt;
        if (fall) begin
            bit_next = boundary ? '0 : bit_cnt + BIT_W'(1);
        end
        take = smp.sample_valid && hold_empty;

        frame_l_next = frame_l;
        frame_r_next = frame_r;
        if (boundary) begin
            frame_l_next = hold_empty ? '0 : hold_l;
            frame_r_next = hold_empty ? '0 : hold_r;
        end

        ws_next = (bit_next >= WS_LO) && (bit_next <= WS_HI);
        if (bit_next < SLOT) begin
            pos  = bit_next;
            word = frame_l_next;
        end else begin
            pos  = bit_next - SLOT;
            word = frame_r_next;
        end
        word    = word << pos;
        d0_next = (pos < DW) ? word[DATA_W-1] : 1'b0;
    end

    // Serializer datapath and holding buffer; disabling acts as a sync reset.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            div_cnt    <= '0;
            bit_cnt    <= '0;
            i2s_bck    <= 1'b0;
            i2s_ws     <= 1'b0;
            i2s_d0     <= 1'b0;
            underrun   <= 1'b0;
            hold_empty <= 1'b1;
            hold_l     <= '0;
            hold_r     <= '0;
            frame_l    <= '0;
            frame_r    <= '0;
        end else if (!ena) begin
            div_cnt    <= '0;
            bit_cnt    <= '0;
            i2s_bck    <= 1'b0;
            i2s_ws     <= 1'b0;
            i2s_d0     <= 1'b0;
            underrun   <= 1'b0;
            hold_empty <= 1'b1;
            hold_l     <= '0;
            hold_r     <= '0;
            frame_l    <= '0;
            frame_r    <= '0;
        end else begin
            div_cnt  <= div_next;
            bit_cnt  <= bit_next;
            i2s_bck  <= (div_next >= DIV_HALF);
            if (fall) begin
                i2s_ws <= ws_next;
                i2s_d0 <= d0_next;
            end
            frame_l  <= frame_l_next;
            frame_r  <= frame_r_next;
            underrun <= flag_underrun;
            // A full buffer blocks intake, so a boundary drain and a new
            // write can only coincide when the buffer was already empty.
            if (boundary) begin
                hold_empty <= 1'b1;
            end
            if (take) begin
                hold_l     <= smp.sample_l;
                hold_r     <= smp.sample_r;
                hold_empty <= 1'b0;
            end
        end
    end

    // Saturating underrun counter; only the hard reset clears it.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            underrun_cnt <= '0;
        end else if (ena && flag_underrun && (underrun_cnt != 8'hFF)) begin
            underrun_cnt <= underrun_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Self-checking bench for i2s_tx_serializer: cycle-level reference model,
// directed frame table, and hand-written corner-case sequences.
module tb_i2s_tx_serializer;
    localparam int W   = 24;
    localparam int S   = 32;
    localparam int D   = 4;
    localparam int FR  = 2 * S * D;
    localparam int SW  = 4;
    localparam int SS  = 6;
    localparam int SD  = 2;
    localparam int SFR = 2 * SS * SD;

    typedef struct {
        int   bit_idx;
        logic ws;
        logic d0;
    } vec_t;

    logic       clk    = 1'b0;
    logic       resetb = 1'b0;
    logic       ena    = 1'b1;
    logic       ena_s  = 1'b1;
    logic       bck, ws, d0, und;
    logic [7:0] ucnt;
    logic       s_bck, s_ws, s_d0, s_und;
    logic [7:0] s_ucnt_dut;

    i2s_tx_serializer_if #(.DATA_W(W))  bus ();
    i2s_tx_serializer_if #(.DATA_W(SW)) sbus ();

    i2s_tx_serializer #(.DATA_W(W), .SLOT_W(S), .BCK_DIV(D)) dut (
        .clk(clk), .resetb(resetb), .ena(ena), .smp(bus),
        .i2s_bck(bck), .i2s_ws(ws), .i2s_d0(d0),
        .underrun(und), .underrun_cnt(ucnt)
    );

    i2s_tx_serializer #(.DATA_W(SW), .SLOT_W(SS), .BCK_DIV(SD)) dut_s (
        .clk(clk), .resetb(resetb), .ena(ena_s), .smp(sbus),
        .i2s_bck(s_bck), .i2s_ws(s_ws), .i2s_d0(s_d0),
        .underrun(s_und), .underrun_cnt(s_ucnt_dut)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // reference model state (main instance)
    int         c = 0;
    logic       m_full = 1'b0;
    logic [W-1:0] m_l = '0, m_r = '0, cur_l = '0, cur_r = '0;
    logic       exp_und = 1'b0;
    int         m_ucnt = 0;
    logic       last_hs = 1'b0;
    // reference model state (small instance, never fed)
    int         sc = 0;
    int         s_ucnt = 0;
    logic       s_exp_und = 1'b0;

    // observation bookkeeping
    logic       ready_prev = 1'b0;
    int         dut_hs_cnt = 0;
    int         und_seen = 0;
    int         rdy_falls = 0;
    logic       cap_en = 1'b0;
    logic       cap_ws [0:63];
    logic       cap_d0 [0:63];

    task automatic check(input string name, input int act, input int exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp_v, $time);
        end
    endtask

    // one clock: advance the model from the inputs seen at the edge, then compare
    task automatic step();
        logic hs;
        int b, p;
        logic [W-1:0] w;
        logic e_bck, e_ws, e_d0;
        logic [12:0] act, expv;
        logic [5:0] bi;
        @(posedge clk);
        hs = bus.sample_valid && !m_full && resetb && ena;
        if (bus.sample_valid && ready_prev) dut_hs_cnt++;
        if (!resetb || !ena) begin
            c = 0; m_full = 1'b0; cur_l = '0; cur_r = '0; exp_und = 1'b0;
            if (!resetb) m_ucnt = 0;
        end else begin
            c++;
            exp_und = 1'b0;
            if (c % FR == 0) begin
                if (m_full) begin
                    cur_l = m_l; cur_r = m_r;
                end else begin
                    cur_l = '0; cur_r = '0;
                    if (c / FR >= 2) begin
                        exp_und = 1'b1;
                        if (m_ucnt < 255) m_ucnt++;
                    end
                end
                m_full = 1'b0;
            end
            if (hs) begin
                m_l = bus.sample_l; m_r = bus.sample_r; m_full = 1'b1;
            end
        end
        last_hs = hs;
        if (!resetb) begin
            sc = 0; s_ucnt = 0; s_exp_und = 1'b0;
        end else begin
            sc++;
            s_exp_und = 1'b0;
            if (sc % SFR == 0 && sc / SFR >= 2) begin
                s_exp_und = 1'b1;
                if (s_ucnt < 255) s_ucnt++;
            end
        end
        #1;
        e_bck = (c % D) >= D / 2;
        b     = (c / D) % (2 * S);
        e_ws  = (b >= S - 1) && (b <= 2 * S - 2);
        if (b < S) begin p = b; w = cur_l; end else begin p = b - S; w = cur_r; end
        w     = w << p;
        e_d0  = (p < W) ? w[W-1] : 1'b0;
        act   = {bck, ws, d0, und, bus.sample_ready, ucnt};
        expv  = {e_bck, e_ws, e_d0, exp_und, !m_full, 8'(m_ucnt)};
        check("main_outputs", int'(act), int'(expv));

        e_bck = (sc % SD) >= SD / 2;
        b     = (sc / SD) % (2 * SS);
        e_ws  = (b >= SS - 1) && (b <= 2 * SS - 2);
        act   = {s_bck, s_ws, s_d0, s_und, sbus.sample_ready, s_ucnt_dut};
        expv  = {e_bck, e_ws, 1'b0, s_exp_und, 1'b1, 8'(s_ucnt)};
        check("small_outputs", int'(act), int'(expv));

        if (und) und_seen++;
        if (ready_prev && !bus.sample_ready) rdy_falls++;
        ready_prev = bus.sample_ready;
        if (cap_en && c >= FR && c < 2 * FR && c % D == 0) begin
            bi = 6'((c / D) % (2 * S));
            cap_ws[bi] = ws;
            cap_d0[bi] = d0;
        end
    endtask

    task automatic run_until(input int target, input string name);
        for (int i = 0; i < 4 * FR && c < target; i++) step();
        if (c != target) begin
            tests++; fails++;
            $display("FAIL %s: cycle budget expired at model cycle %0d, wanted %0d", name, c, target);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [14];
        int   saved;
        int   rises [$];
        logic prev_bck;

        // expected first played frame for L=0x800001, R=0x7FFFFE
        tbl[0]  = '{bit_idx: 0,  ws: 1'b0, d0: 1'b1};
        tbl[1]  = '{bit_idx: 1,  ws: 1'b0, d0: 1'b0};
        tbl[2]  = '{bit_idx: 22, ws: 1'b0, d0: 1'b0};
        tbl[3]  = '{bit_idx: 23, ws: 1'b0, d0: 1'b1};
        tbl[4]  = '{bit_idx: 24, ws: 1'b0, d0: 1'b0};
        tbl[5]  = '{bit_idx: 30, ws: 1'b0, d0: 1'b0};
        tbl[6]  = '{bit_idx: 31, ws: 1'b1, d0: 1'b0};
        tbl[7]  = '{bit_idx: 32, ws: 1'b1, d0: 1'b0};
        tbl[8]  = '{bit_idx: 33, ws: 1'b1, d0: 1'b1};
        tbl[9]  = '{bit_idx: 54, ws: 1'b1, d0: 1'b1};
        tbl[10] = '{bit_idx: 55, ws: 1'b1, d0: 1'b0};
        tbl[11] = '{bit_idx: 56, ws: 1'b1, d0: 1'b0};
        tbl[12] = '{bit_idx: 62, ws: 1'b1, d0: 1'b0};
        tbl[13] = '{bit_idx: 63, ws: 1'b0, d0: 1'b0};

        bus.sample_valid  = 1'b0;
        bus.sample_l      = '0;
        bus.sample_r      = '0;
        sbus.sample_valid = 1'b0;
        sbus.sample_l     = '0;
        sbus.sample_r     = '0;

        // reset state
        repeat (3) step();
        resetb = 1'b1;

        // single transfer before the first boundary, then inspect frame 1
        cap_en = 1'b1;
        repeat (10) step();
        bus.sample_l = 24'h800001; bus.sample_r = 24'h7FFFFE; bus.sample_valid = 1'b1;
        step();
        bus.sample_valid = 1'b0;
        run_until(2 * FR, "frame1_wait");
        cap_en = 1'b0;
        for (int i = 0; i < 14; i++) begin
            check($sformatf("frame1_ws_bit%0d", tbl[i].bit_idx), int'(cap_ws[6'(tbl[i].bit_idx)]), int'(tbl[i].ws));
            check($sformatf("frame1_d0_bit%0d", tbl[i].bit_idx), int'(cap_d0[6'(tbl[i].bit_idx)]), int'(tbl[i].d0));
        end

        // continuous streaming for 8 frames
        dut_hs_cnt = 0; und_seen = 0; rdy_falls = 0;
        bus.sample_l = W'($urandom); bus.sample_r = W'($urandom); bus.sample_valid = 1'b1;
        for (int i = 0; i < 8 * FR; i++) begin
            step();
            if (last_hs) begin
                bus.sample_l = W'($urandom); bus.sample_r = W'($urandom);
            end
        end
        bus.sample_valid = 1'b0;
        check("stream_transfers", dut_hs_cnt, 8);
        check("stream_underruns", und_seen, 0);
        check("stream_ready_falls", rdy_falls, 8);

        // handshake in the exact boundary cycle with an empty buffer
        run_until(12 * FR - 1, "simul_wait");
        bus.sample_l = 24'hC00003; bus.sample_r = 24'h000001; bus.sample_valid = 1'b1;
        step();
        bus.sample_valid = 1'b0;
        check("simul_underrun", int'(und), 1);
        check("simul_ready", int'(bus.sample_ready), 0);
        run_until(13 * FR, "simul_next");
        check("simul_next_msb", int'(d0), 1);
        check("simul_next_underrun", int'(und), 0);

        // valid held for 100 clk while the buffer is full
        repeat (10) step();
        bus.sample_l = 24'hA5A5A5; bus.sample_r = 24'h123456; bus.sample_valid = 1'b1;
        step();
        bus.sample_l = 24'h5A5A5A; bus.sample_r = 24'h654321;
        dut_hs_cnt = 0;
        repeat (100) step();
        bus.sample_valid = 1'b0;
        check("held_valid_transfers", dut_hs_cnt, 0);
        run_until(14 * FR, "held_wait");
        check("held_first_plays", int'(d0), 1);

        // randomized traffic
        for (int i = 0; i < 6 * FR; i++) begin
            step();
            bus.sample_valid = ($urandom_range(0, 3) == 0);
            bus.sample_l     = W'($urandom);
            bus.sample_r     = W'($urandom);
        end
        bus.sample_valid = 1'b0;

        // ena low with a buffered sample: sample dropped, counter kept
        bus.sample_l = 24'hFFFFFF; bus.sample_r = 24'hFFFFFF; bus.sample_valid = 1'b1;
        for (int i = 0; i < 2 * FR; i++) begin
            step();
            if (last_hs) break;
        end
        bus.sample_valid = 1'b0;
        if (!last_hs) begin
            tests++; fails++;
            $display("FAIL ena_fill: no transfer within budget");
        end
        repeat (3) step();
        saved = m_ucnt;
        ena = 1'b0;
        repeat (5) step();
        ena = 1'b1;
        check("ena_cnt_kept", int'(ucnt), saved);
        run_until(FR, "ena_first_wait");
        check("ena_first_underrun", int'(und), 0);
        check("ena_first_d0", int'(d0), 0);
        run_until(2 * FR, "ena_second_wait");
        check("ena_second_underrun", int'(und), 1);

        // asynchronous reset mid-frame at bit 40
        run_until(2 * FR + 40 * D, "rst_wait");
        check("pre_reset_ws", int'(ws), 1);
        #3;
        resetb = 1'b0;
        #1;
        check("async_reset", int'({bck, ws, d0, und, bus.sample_ready, ucnt}), int'(13'b0000_1_00000000));
        repeat (3) step();
        resetb = 1'b1;
        prev_bck = bck;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bck && !prev_bck) rises.push_back(c);
            prev_bck = bck;
        end
        check("restart_bck_rises", rises.size() >= 2 ? 1 : 0, 1);
        if (rises.size() >= 2) check("restart_bck_period", rises[1] - rises[0], D);

        // 300 frames with no samples on the small instance: counter saturates
        repeat (300 * SFR) step();
        check("sat_cnt", int'(s_ucnt_dut), 255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
